hmove_entry_sequencer: RTL and testbench

- Human-side front end for the move game. The game FSM consumes a 4-bit human move and produces a 4-bit BCD computer move plus a win flag; this block is the opposite end of that interface.
- Synchronises the raw enter pushbutton and validates the switch-selected square against a 9-bit occupancy board.
- Issues one legal hMove per press with a one-cycle step strobe, waits for the game's cMove, and records both squares.
- Sits between the board switches/KEY and the game FSM; replaces driving the game clock directly from a pushbutton.

---
 rtl/hmove_entry_sequencer_pkg.sv | 28 ++
 rtl/hmove_entry_sequencer_if.sv | 13 +
 rtl/hmove_entry_sequencer_button_conditioner.sv | 79 +++++++
 rtl/hmove_entry_sequencer.sv | 167 ++++++++++++++++
 tb/tb_hmove_entry_sequencer.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/hmove_entry_sequencer_pkg.sv
// Shared types and constants for the human-move entry sequencer.
// Optional feature macro used by this bundle: HMOVE_DEBOUNCE_EN.
package hmove_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CHECK = 3'd1,
    ISSUE = 3'd2,
    WAIT  = 3'd3,
    DONE  = 3'd4
  } state_e;

  localparam int         NUM_SQUARES = 9;
  localparam logic [3:0] MAX_SQUARE  = 4'd8;
  localparam logic [8:0] BOARD_FULL  = 9'h1FF;

  // One-hot board bit for a square; squares above 8 map to no bit at all.
  function automatic logic [8:0] square_mask(input logic [3:0] sq);
    logic [8:0] m;
    if (sq <= MAX_SQUARE) begin
      m = 9'd1 << sq;
    end else begin
      m = 9'd0;
    end
    return m;
  endfunction

endpackage

// File: rtl/hmove_entry_sequencer_if.sv
// Game-side link of the sequencer: the human move goes out with a step
// strobe, the computer move and win flag come back.
interface hmove_entry_sequencer_if;
  logic [3:0] hMove;
  logic       step_pulse;
  logic [3:0] cMove;
  logic       win;

  // Sequencer side.
  modport master (output hMove, output step_pulse, input cMove, input win);
  // Game FSM side.
  modport slave  (input hMove, input step_pulse, output cMove, output win);
endinterface

// File: rtl/hmove_entry_sequencer_button_conditioner.sv
// Pushbutton conditioner: synchroniser, optional debounce, press-edge detect.
// Debounce is built only when HMOVE_DEBOUNCE_EN is defined.
// The press output is high for one cycle per button press.
module button_conditioner #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clock,
  input  logic reset_L,
  input  logic btn_L,
  output logic press
);

  // Synchroniser carries the "pressed" level (inverted button), cleared to released.
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   level_s;
  logic                   prev_q;

  // Shift the asynchronous button level into the clock domain.
  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], ~btn_L};
    end
  end

`ifdef HMOVE_DEBOUNCE_EN
  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] deb_cnt_q, deb_cnt_d;
  logic             stable_q, stable_d;

  // Accept a new level only after it has differed from the stable one for the full window.
  always_comb begin
    stable_d  = stable_q;
    deb_cnt_d = '0;
    if (sync_q[SYNC_STAGES-1] != stable_q) begin
      if (deb_cnt_q == CNT_LAST) begin
        stable_d  = sync_q[SYNC_STAGES-1];
        deb_cnt_d = '0;
      end else begin
        deb_cnt_d = deb_cnt_q + 1'b1;
      end
    end else begin
      deb_cnt_d = '0;
    end
  end

  // Debounce state registers.
  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      stable_q  <= 1'b0;
      deb_cnt_q <= '0;
    end else begin
      stable_q  <= stable_d;
      deb_cnt_q <= deb_cnt_d;
    end
  end

  assign level_s = stable_q;
`else
  assign level_s = sync_q[SYNC_STAGES-1];
`endif

  // Remember the previous conditioned level for edge detection.
  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= level_s;
    end
  end

  // A press is the released-to-pressed transition; a held button gives one pulse.
  assign press = level_s & ~prev_q;

endmodule

// File: rtl/hmove_entry_sequencer.sv
// Human-move entry sequencer: turns a switch value plus an enter press into
// one validated hMove with a step strobe, then records the computer's reply.
// Optional feature macro: HMOVE_DEBOUNCE_EN (debounce in the button conditioner).
module hmove_entry_sequencer
  import hmove_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int RESP_CYCLES     = 1,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                    clock,
  input  logic                    reset_L,
  input  logic [3:0]              sw_move,
  input  logic                    enter_L,
  hmove_entry_sequencer_if.master game,
  output logic                    illegal,
  output logic [8:0]              board,
  output logic [3:0]              turn_count,
  output logic                    game_over
);

  localparam logic [3:0] RESP_LAST = 4'(RESP_CYCLES - 1);

  state_e     state_q, state_d;
  logic [3:0] hold_q, hold_d;
  logic [3:0] hmove_q, hmove_d;
  logic       illegal_q, illegal_d;
  logic [8:0] board_q, board_d;
  logic [3:0] turn_q, turn_d;
  logic [3:0] wait_cnt_q, wait_cnt_d;

  logic       press_s;
  logic       legal_s;
  logic       sample_s;
  logic [8:0] board_upd_s;
  logic       step_pulse_s;
  logic       game_over_s;

  button_conditioner #(
    .SYNC_STAGES     (SYNC_STAGES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_enter (
    .clock   (clock),
    .reset_L (reset_L),
    .btn_L   (enter_L),
    .press   (press_s)
  );

  // A move is legal when it names a real square that is still empty.
  assign legal_s = (hold_q <= MAX_SQUARE) &&
                   ((board_q & square_mask(hold_q)) == 9'd0);

  // cMove is sampled on the last response-wait cycle.
  assign sample_s = (state_q == WAIT) && (wait_cnt_q == RESP_LAST);

  // An illegal or already-taken cMove leaves the board as it is.
  assign board_upd_s = board_q | square_mask(game.cMove);

  // State register.
  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decision.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (press_s) state_d = CHECK;
        else         state_d = IDLE;
      end
      CHECK: begin
        if (legal_s) state_d = ISSUE;
        else         state_d = IDLE;
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (sample_s) begin
          if (game.win || (board_upd_s == BOARD_FULL)) state_d = DONE;
          else                                         state_d = IDLE;
        end else begin
          state_d = WAIT;
        end
      end
      DONE:    state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values: latch the switch, accept/reject, record both moves.
  always_comb begin
    hold_d     = hold_q;
    hmove_d    = hmove_q;
    illegal_d  = illegal_q;
    board_d    = board_q;
    turn_d     = turn_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      IDLE: begin
        if (press_s) hold_d = sw_move;
        else         hold_d = hold_q;
      end
      CHECK: begin
        if (legal_s) begin
          hmove_d   = hold_q;
          illegal_d = 1'b0;
        end else begin
          illegal_d = 1'b1;
        end
      end
      ISSUE: begin
        board_d    = board_q | square_mask(hmove_q);
        turn_d     = turn_q + 4'd1;
        wait_cnt_d = 4'd0;
      end
      WAIT: begin
        if (sample_s) board_d    = board_upd_s;
        else          wait_cnt_d = wait_cnt_q + 4'd1;
      end
      default: begin
        hold_d = hold_q;
      end
    endcase
  end

  // Datapath registers; reset aborts any turn in progress.
  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      hold_q     <= 4'd0;
      hmove_q    <= 4'd0;
      illegal_q  <= 1'b0;
      board_q    <= 9'd0;
      turn_q     <= 4'd0;
      wait_cnt_q <= 4'd0;
    end else begin
      hold_q     <= hold_d;
      hmove_q    <= hmove_d;
      illegal_q  <= illegal_d;
      board_q    <= board_d;
      turn_q     <= turn_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // State-decoded outputs: strobe in ISSUE, sticky game_over in DONE.
  always_comb begin
    step_pulse_s = 1'b0;
    game_over_s  = 1'b0;
    case (state_q)
      ISSUE:   step_pulse_s = 1'b1;
      DONE:    game_over_s  = 1'b1;
      default: step_pulse_s = 1'b0;
    endcase
  end

  assign game.hMove      = hmove_q;
  assign game.step_pulse = step_pulse_s;
  assign illegal         = illegal_q;
  assign board           = board_q;
  assign turn_count      = turn_q;
  assign game_over       = game_over_s;

endmodule

// File: tb/tb_hmove_entry_sequencer.sv
// Scoreboard bench for hmove_entry_sequencer: directed turns, a held button,
// a mid-turn reset and randomized games against a square-array game model.
module tb_hmove_entry_sequencer;

  localparam int SETTLE = 40;
`ifdef HMOVE_DEBOUNCE_EN
  localparam int HOLD_EXTRA = 20;
`else
  localparam int HOLD_EXTRA = 0;
`endif

  logic       clock = 1'b0;
  logic       reset_L;
  logic       enter_L;
  logic [3:0] sw_move;
  logic       illegal;
  logic [8:0] board;
  logic [3:0] turn_count;
  logic       game_over;

  hmove_entry_sequencer_if gif ();

  hmove_entry_sequencer #(
    .SYNC_STAGES     (2),
    .RESP_CYCLES     (1),
    .DEBOUNCE_CYCLES (16)
  ) dut (
    .clock      (clock),
    .reset_L    (reset_L),
    .sw_move    (sw_move),
    .enter_L    (enter_L),
    .game       (gif),
    .illegal    (illegal),
    .board      (board),
    .turn_count (turn_count),
    .game_over  (game_over)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Reference model of the game as seen from the human side.
  bit         occ [9];
  int         m_turns;
  bit         m_illegal;
  bit         m_over;
  int         m_hmove;
  logic [3:0] exp_q [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [8:0] m_board();
    logic [8:0] b;
    b = 9'd0;
    for (int i = 0; i < 9; i++) if (occ[i]) b[i] = 1'b1;
    return b;
  endfunction

  function automatic bit m_full();
    bit f;
    f = 1'b1;
    for (int i = 0; i < 9; i++) if (!occ[i]) f = 1'b0;
    return f;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 9; i++) occ[i] = 1'b0;
    m_turns   = 0;
    m_illegal = 1'b0;
    m_over    = 1'b0;
    m_hmove   = 0;
    exp_q.delete();
  endtask

  // Monitor: every step strobe must match the oldest expected human move.
  always @(negedge clock) begin
    if (reset_L === 1'b1 && gif.step_pulse === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_step_pulse hMove=%0d expected=no_strobe at %0t", gif.hMove, $time);
      end else begin
        chk("step_hMove", {28'd0, gif.hMove}, {28'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic check_state(input string tag);
    chk({tag, "_board"},      {23'd0, board},      {23'd0, m_board()});
    chk({tag, "_turn_count"}, {28'd0, turn_count}, 32'(m_turns));
    chk({tag, "_illegal"},    {31'd0, illegal},    {31'd0, m_illegal});
    chk({tag, "_game_over"},  {31'd0, game_over},  {31'd0, m_over});
    chk({tag, "_hMove"},      {28'd0, gif.hMove},  32'(m_hmove));
    chk({tag, "_strobes_left"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic apply_reset();
    @(negedge clock);
    reset_L = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      enter_L = ~enter_L;
    end
    chk("rst_hMove",      {28'd0, gif.hMove},      32'd0);
    chk("rst_step_pulse", {31'd0, gif.step_pulse}, 32'd0);
    chk("rst_illegal",    {31'd0, illegal},        32'd0);
    chk("rst_board",      {23'd0, board},          32'd0);
    chk("rst_turn_count", {28'd0, turn_count},     32'd0);
    chk("rst_game_over",  {31'd0, game_over},      32'd0);
    enter_L = 1'b1;
    @(negedge clock);
    reset_L = 1'b1;
    model_clear();
    repeat (SETTLE) @(negedge clock);
    check_state("post_reset");
  endtask

  // One press with cMove/win held stable for the whole turn; model updated up front.
  task automatic do_press(input logic [3:0] sq, input logic [3:0] cm, input logic w, input int hold);
    @(negedge clock);
    sw_move  = sq;
    gif.cMove = cm;
    gif.win   = w;
    if (!m_over) begin
      if (sq <= 4'd8 && !occ[sq]) begin
        occ[sq] = 1'b1;
        m_turns++;
        m_illegal = 1'b0;
        m_hmove   = int'(sq);
        exp_q.push_back(sq);
        if (cm <= 4'd8) occ[cm] = 1'b1;
        if (w || m_full()) m_over = 1'b1;
      end else begin
        m_illegal = 1'b1;
      end
    end
    enter_L = 1'b0;
    repeat (hold + HOLD_EXTRA) @(negedge clock);
    enter_L = 1'b1;
    repeat (SETTLE) @(negedge clock);
    check_state("turn");
  endtask

  // Reset while the sequencer waits for the computer's reply.
  task automatic reset_in_wait();
    bit seen;
    seen = 1'b0;
    @(negedge clock);
    sw_move   = 4'd2;
    gif.cMove = 4'd6;
    gif.win   = 1'b0;
    exp_q.push_back(4'd2);
    enter_L = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clock);
      if (gif.step_pulse === 1'b1) seen = 1'b1;
    end
    chk("wait_reset_strobe_seen", {31'd0, seen}, 32'd1);
    @(posedge clock);
    #1 reset_L = 1'b0;
    @(negedge clock);
    enter_L = 1'b1;
    model_clear();
    check_state("wait_reset");
    @(negedge clock);
    reset_L = 1'b1;
    repeat (SETTLE) @(negedge clock);
    check_state("wait_reset_after");
  endtask

  initial begin
    logic [3:0] sq, cm;
    logic       w;
    reset_L   = 1'b0;
    enter_L   = 1'b1;
    sw_move   = 4'd0;
    gif.cMove = 4'd0;
    gif.win   = 1'b0;
    model_clear();

    apply_reset();

    // Directed game: legal, occupied, legal, out of range, held, win, ignored.
    do_press(4'd4,  4'd0, 1'b0, 3);
    do_press(4'd0,  4'd1, 1'b0, 4);
    do_press(4'd8,  4'd2, 1'b0, 5);
    do_press(4'd12, 4'd3, 1'b0, 2);
    do_press(4'd1,  4'd9, 1'b0, 100);
    do_press(4'd3,  4'd5, 1'b1, 3);
    do_press(4'd6,  4'd7, 1'b0, 3);

    apply_reset();
    reset_in_wait();

`ifdef HMOVE_DEBOUNCE_EN
    // A short glitch must not count as a press.
    @(negedge clock);
    sw_move = 4'd5;
    enter_L = 1'b0;
    repeat (5) @(negedge clock);
    enter_L = 1'b1;
    repeat (SETTLE) @(negedge clock);
    check_state("glitch");
`endif

    // Random games until a win or a full board, with some illegal picks.
    for (int g = 0; g < 16; g++) begin
      apply_reset();
      for (int p = 0; p < 12; p++) begin
        if ($urandom_range(0, 6) == 0) sq = 4'($urandom_range(9, 15));
        else                           sq = 4'($urandom_range(0, 8));
        if ($urandom_range(0, 5) == 0) cm = 4'($urandom_range(9, 15));
        else                           cm = 4'($urandom_range(0, 8));
        w = ($urandom_range(0, 24) == 0);
        do_press(sq, cm, w, int'($urandom_range(1, 12)));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
